// File: rtl/controlador_de_acesso.sv
`default_nettype none
// ============================================================================
// Module   : controlador_de_acesso
// Purpose  : Timed-session arbiter downstream of the two-interface priority
//            comparator, with a one-entry wait register for the losing user.
// Revision : 1.0 - initial release
// ============================================================================
module controlador_de_acesso #(
  parameter int TEMPO_SESSAO = 8,
  parameter int LARGURA_CONT = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] User0,
  input  logic [2:0] User1,
  input  logic [1:0] S,
  input  logic [2:0] UserMenorPrioridade,
  input  logic       liberar,
  output logic [1:0] concede,
  output logic [2:0] usuario_ativo,
  output logic [2:0] usuario_espera,
  output logic       espera_valida,
  output logic       ocupado,
  output logic       erro
);

  typedef enum logic [1:0] {
    OCIOSO = 2'd0,
    SESSAO = 2'd1,
    ERRO   = 2'd2
  } estado_t;

  localparam logic [LARGURA_CONT-1:0] C_ULTIMO = LARGURA_CONT'(TEMPO_SESSAO - 1);
  localparam logic [LARGURA_CONT-1:0] C_UM     = LARGURA_CONT'(1);

  estado_t                 r_estado;
  logic [LARGURA_CONT-1:0] r_contador;
  logic                    r_if_espera;  // 1 = parked user belongs to interface 1
  logic                    w_codigos_ok;
  logic                    w_fim;

  function automatic logic codigo_valido(input logic [2:0] codigo);
    case (codigo)
      3'b000, 3'b110, 3'b001, 3'b011, 3'b101: return 1'b1;
      default:                                return 1'b0;
    endcase
  endfunction

  assign w_codigos_ok = codigo_valido(User0) && codigo_valido(User1);
  // Terminal count and an early release coinciding collapse into one end event.
  assign w_fim        = (r_contador == C_ULTIMO) || liberar;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_estado       <= OCIOSO;
      r_contador     <= '0;
      r_if_espera    <= 1'b0;
      concede        <= 2'b00;
      usuario_ativo  <= 3'b000;
      usuario_espera <= 3'b000;
      espera_valida  <= 1'b0;
      ocupado        <= 1'b0;
      erro           <= 1'b0;
    end else begin
      case (r_estado)
        OCIOSO: begin
          r_contador <= '0;
          if (S == 2'b11 || !w_codigos_ok) begin
            r_estado <= ERRO;
            concede  <= 2'b00;
            erro     <= 1'b1;
          end else if (S == 2'b10 || S == 2'b01) begin
            r_estado      <= SESSAO;
            ocupado       <= 1'b1;
            concede       <= (S == 2'b10) ? 2'b01 : 2'b10;
            usuario_ativo <= (S == 2'b10) ? User0 : User1;
            if (UserMenorPrioridade != 3'b000) begin
              usuario_espera <= UserMenorPrioridade;
              espera_valida  <= 1'b1;
              r_if_espera    <= (S == 2'b10);
            end
          end
        end

        SESSAO: begin
          if (w_fim) begin
            r_contador <= '0;
            if (espera_valida) begin
              // Hand over straight to the parked user with no idle cycle.
              concede        <= r_if_espera ? 2'b10 : 2'b01;
              usuario_ativo  <= usuario_espera;
              usuario_espera <= 3'b000;
              espera_valida  <= 1'b0;
            end else begin
              r_estado      <= OCIOSO;
              concede       <= 2'b00;
              usuario_ativo <= 3'b000;
              ocupado       <= 1'b0;
            end
          end else begin
            r_contador <= r_contador + C_UM;
          end
        end

        ERRO: begin
          r_contador <= '0;
          concede    <= 2'b00;
          if (User0 == 3'b000 && User1 == 3'b000) begin
            r_estado <= OCIOSO;
            erro     <= 1'b0;
          end
        end

        default: begin
          r_estado      <= OCIOSO;
          r_contador    <= '0;
          concede       <= 2'b00;
          usuario_ativo <= 3'b000;
          ocupado       <= 1'b0;
          erro          <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
